// File: rtl/jtag_bb_pkg.sv
// Shared types for the JTAG bit-bang sequencer.
//   jtag_bb_op_e       : command opcode carried in cmd[4:3]
//   jtag_bb_state_e    : sequencer state
//   jtag_bb_cmd_t      : packed {op, payload} view of the 5-bit command word
//   JTAG_BB_SAMPLE_DLY : cycles spent in SAMPLE before the TDO capture
package jtag_bb_pkg;

    typedef enum logic [1:0] {
        OpWrite = 2'd0,
        OpRead  = 2'd1,
        OpReset = 2'd2,
        OpBlink = 2'd3
    } jtag_bb_op_e;

    typedef enum logic [1:0] {
        StIdle,
        StHold,
        StSample,
        StResp
    } jtag_bb_state_e;

    typedef struct packed {
        jtag_bb_op_e op;
        logic [2:0]  payload;
    } jtag_bb_cmd_t;

    // Matches the synchronizer depth, so the sample taken at the end of SAMPLE
    // is the TDO level seen in the cycle the READ was accepted.
    localparam int unsigned JTAG_BB_SAMPLE_DLY = 2;

endpackage

// File: rtl/jtag_tdo_sync.sv
// Two-flop synchronizer for the asynchronous TDO input.
// Ports:
//   clk_i : system clock
//   rst_i : asynchronous active-high reset, clears both flops to 0
//   d_i   : asynchronous input
//   q_o   : synchronized output, two clocks behind d_i
module jtag_tdo_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/jtag_bitbang_sequencer.sv
// Paces bit-bang commands onto the JTAG pins with a programmable minimum hold
// time, and returns TDO samples over a valid/ready response channel.
// Ports:
//   clk_i, rst_i            : clock, asynchronous active-high reset
//   enable_i                : low forces IDLE and discards a pending response
//   half_period_i           : hold cycles after each WRITE (0 acts as 1)
//   cmd_valid_i/cmd_ready_o : command handshake, cmd_i = {op[1:0], payload[2:0]}
//   rsp_valid_o/rsp_ready_i : response handshake, rsp_data_o = sampled TDO
//   jtag_*_o                : registered JTAG pins, jtag_tdo_i asynchronous TDO
//   blink_o                 : activity LED level
//   busy_o                  : state is not IDLE
module jtag_bitbang_sequencer
    import jtag_bb_pkg::*;
#(
    parameter int unsigned DIV_W   = 8,
    parameter int unsigned RST_MIN = 4  // must be >= 1 and fit in DIV_W bits
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             enable_i,
    input  logic [DIV_W-1:0] half_period_i,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [4:0]       cmd_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic             rsp_data_o,
    output logic             jtag_tck_o,
    output logic             jtag_tms_o,
    output logic             jtag_tdi_o,
    output logic             jtag_trst_o,
    output logic             jtag_srst_o,
    input  logic             jtag_tdo_i,
    output logic             blink_o,
    output logic             busy_o
);

    jtag_bb_state_e state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic tck_q, tck_d;
    logic tms_q, tms_d;
    logic tdi_q, tdi_d;
    logic trst_q, trst_d;
    logic srst_q, srst_d;
    logic blink_q, blink_d;
    logic rsp_valid_q, rsp_valid_d;
    logic rsp_data_q, rsp_data_d;
    // Keeps cmd_ready low while reset is asserted and until the first edge after
    // release, even though the state is already IDLE.
    logic armed_q;

    logic tdo_sync;
    logic cmd_ready;
    logic [DIV_W-1:0] write_hold;
    jtag_bb_cmd_t cmd;

    assign cmd = jtag_bb_cmd_t'(cmd_i);

    jtag_tdo_sync u_tdo_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (jtag_tdo_i),
        .q_o   (tdo_sync)
    );

    assign cmd_ready  = armed_q && enable_i && (state_q == StIdle);
    assign write_hold = (half_period_i == '0) ? DIV_W'(1) : half_period_i;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        tck_d       = tck_q;
        tms_d       = tms_q;
        tdi_d       = tdi_q;
        trst_d      = trst_q;
        srst_d      = srst_q;
        blink_d     = blink_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;

        if (!enable_i) begin
            // Pins and the last response data are left untouched.
            state_d     = StIdle;
            cnt_d       = '0;
            rsp_valid_d = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (cmd_valid_i && cmd_ready) begin
                        unique case (cmd.op)
                            OpWrite: begin
                                {tck_d, tms_d, tdi_d} = cmd.payload;
                                cnt_d   = write_hold;
                                state_d = StHold;
                            end
                            OpRead: begin
                                cnt_d   = DIV_W'(JTAG_BB_SAMPLE_DLY);
                                state_d = StSample;
                            end
                            OpReset: begin
                                {trst_d, srst_d} = cmd.payload[1:0];
                                cnt_d   = DIV_W'(RST_MIN);
                                state_d = StHold;
                            end
                            OpBlink: begin
                                blink_d = cmd.payload[0];
                            end
                        endcase
                    end
                end
                StHold: begin
                    cnt_d = cnt_q - DIV_W'(1);
                    if (cnt_q <= DIV_W'(1)) begin
                        state_d = StIdle;
                    end
                end
                StSample: begin
                    cnt_d = cnt_q - DIV_W'(1);
                    if (cnt_q <= DIV_W'(1)) begin
                        rsp_data_d  = tdo_sync;
                        rsp_valid_d = 1'b1;
                        state_d     = StResp;
                    end
                end
                StResp: begin
                    if (rsp_ready_i) begin
                        rsp_valid_d = 1'b0;
                        state_d     = StIdle;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            tck_q       <= 1'b0;
            tms_q       <= 1'b0;
            tdi_q       <= 1'b0;
            trst_q      <= 1'b0;
            srst_q      <= 1'b0;
            blink_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 1'b0;
            armed_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tck_q       <= tck_d;
            tms_q       <= tms_d;
            tdi_q       <= tdi_d;
            trst_q      <= trst_d;
            srst_q      <= srst_d;
            blink_q     <= blink_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            armed_q     <= 1'b1;
        end
    end

    assign cmd_ready_o = cmd_ready;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = rsp_data_q;
    assign jtag_tck_o  = tck_q;
    assign jtag_tms_o  = tms_q;
    assign jtag_tdi_o  = tdi_q;
    assign jtag_trst_o = trst_q;
    assign jtag_srst_o = srst_q;
    assign blink_o     = blink_q;
    assign busy_o      = (state_q != StIdle);

endmodule

// File: doc/jtag_bitbang_sequencer.md
# jtag_bitbang_sequencer

Paces remote-bitbang style commands onto the JTAG pins. It accepts one command per handshake from the DPI/host side, drives TCK/TMS/TDI/TRST/SRST/blink with a programmable minimum hold time, samples TDO on request and returns it over a valid/ready response channel. It sits between the bit-bang command source and the DUT TAP, so a fast host cannot violate target TCK timing.

## Interface
- `DIV_W`, 8: width of the half-period hold counter.
- `RST_MIN`, 4: minimum cycles any RESET command holds the pins before the next command is accepted.
- `clk_i` in 1: system clock; all logic on the rising edge.
- `rst_i` in 1: reset, asynchronous, active-high.
- `enable_i` in 1: sequencer enable; low forces IDLE.
- `half_period_i` in DIV_W: hold cycles after each WRITE; 0 is treated as 1.
- `cmd_valid_i` in 1: command present.
- `cmd_ready_o` out 1: command accepted when valid and ready are both high.
- `cmd_i` in 5: bits [4:3] are the opcode, bits [2:0] are the payload.
- `rsp_valid_o` out 1: TDO sample available.
- `rsp_ready_i` in 1: response consumed.
- `rsp_data_o` out 1: sampled TDO.
- `jtag_tck_o`, `jtag_tms_o`, `jtag_tdi_o`, `jtag_trst_o`, `jtag_srst_o` out 1 each: registered JTAG pins.
- `jtag_tdo_i` in 1: asynchronous TDO from the target.
- `blink_o` out 1: activity LED.
- `busy_o` out 1: high whenever the state is not IDLE.

## Operation
- Opcodes:
  - WRITE=0: payload is {tck,tms,tdi}.
  - READ=1: sample TDO.
  - RESET=2: payload[1:0] is {trst,srst}.
  - BLINK=3: payload[0] is the blink level.
- States are IDLE, HOLD, SAMPLE, RESP.
- `cmd_ready_o` = (state==IDLE) && `enable_i`.
- IDLE, on accept:
  - WRITE: load tck/tms/tdi; counter = max(half_period_i,1); go to HOLD.
  - RESET: load trst/srst; counter = RST_MIN; go to HOLD.
  - BLINK: load blink; stay in IDLE, so back-to-back accepts are allowed.
  - READ: counter = 2; go to SAMPLE.
- HOLD: decrement the counter each cycle; at 1, go to IDLE.
- SAMPLE: decrement the counter each cycle. When it reaches 1:
  - capture the synchronized TDO into `rsp_data_o`;
  - set `rsp_valid_o`;
  - go to RESP.
- RESP: hold `rsp_valid_o` and `rsp_data_o` stable until `rsp_ready_i`; on the handshake, clear valid and go to IDLE.
- Pins change only on accepted commands. They keep their value through HOLD, SAMPLE, RESP and enable deassertion.
- `enable_i` low in any state:
  - next state is IDLE;
  - the counter is cleared;
  - `rsp_valid_o` is cleared, so a pending response is discarded;
  - pins are held at their last values.
- `half_period_i` is sampled only at WRITE accept. Changing it mid-HOLD has no effect on the current hold.
- Counter width is DIV_W; RST_MIN must fit in DIV_W. There is no wrap, because the counter only decrements to 1.
- Reset values: all pins, `blink_o`, `rsp_valid_o`, `rsp_data_o`, `busy_o` and `cmd_ready_o` are 0; state is IDLE; the TDO synchronizer is 0.

## Timing
- WRITE accepted in cycle N:
  - pins show the new value in cycle N+1;
  - `cmd_ready_o` is low for cycles N+1 .. N+H, where H = max(half_period_i,1);
  - `cmd_ready_o` is high again at N+H+1.
- With steady valid, the minimum command spacing is H+1 cycles for WRITE and RST_MIN+1 cycles for RESET.
- BLINK accepted in cycle N: `blink_o` updates at N+1, and `cmd_ready_o` stays high.
- READ accepted in cycle N:
  - `rsp_valid_o` rises at N+3;
  - `rsp_data_o` is `jtag_tdo_i` as it was two clocks earlier, through the 2-flop synchronizer.
- READ response handshake in cycle M: `rsp_valid_o` is low at M+1 and `cmd_ready_o` is high at M+1.
- `rsp_ready_i` high before `rsp_valid_o` has no effect.
- Asynchronous reset mid-HOLD or mid-RESP: all outputs go to their reset values immediately.

## Structure
- Package `jtag_bb_pkg` holds:
  - the opcode enum `jtag_bb_op_e`;
  - the state enum `jtag_bb_state_e`;
  - the packed struct `jtag_bb_cmd_t` {op[1:0], payload[2:0]};
  - the constant `JTAG_BB_SAMPLE_DLY=2`.
- Sub-module `jtag_tdo_sync` is a 2-flop synchronizer with asynchronous reset to 0. It is instantiated once on `jtag_tdo_i`.

## Test plan
- Reset: assert `rst_i` mid-HOLD -> all pins and `rsp_valid_o` are 0 immediately; `cmd_ready_o` is 1 one cycle after release with `enable_i`=1.
- WRITE pacing: half_period_i=3, two WRITEs 3'b110 and 3'b011 back-to-back -> tck/tms/tdi = 1/1/0 at N+1, ready low 3 cycles, second write lands at N+5.
- half_period_i=0: WRITE -> ready low exactly 1 cycle; spacing is 2 cycles.
- READ with `jtag_tdo_i`=1 and rsp_ready held low 5 cycles -> rsp_valid at N+3, data=1, stable until the handshake; ready returns the next cycle.
- RESET payload 2'b10 with RST_MIN=4 -> trst=1, srst=0 at N+1; the next command is accepted no earlier than N+5. A following BLINK 1 -> blink_o=1 with no stall.
- Drop `enable_i` while in RESP -> rsp_valid_o is 0 the next cycle, state is IDLE, pins are unchanged.
